// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller:
// boot/interrupt/exception vectors, datapath width and FSM state encoding.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_VEC = 32'h8000_0000;
    localparam word_t IRQ_VEC   = 32'h8000_0004;
    localparam word_t EXC_VEC   = 32'h8000_0008;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Pipeline <-> fetch controller signal bundle. The master is the pipeline
// (hazard/branch/trap sources); the slave is fetch_ctrl.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic        stall;
    logic        branch_taken;
    word_t       branch_target;
    logic        jump;
    word_t       jump_target;
    logic        jr;
    word_t       jr_target;
    logic        irq;
    logic        exc;

    logic [30:0] rom_addr;
    word_t       pc;
    word_t       pc_plus4;
    logic        if_valid;
    logic        flush;
    logic        epc_we;
    word_t       epc;
    logic        irq_ack;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               jr, jr_target, irq, exc,
        input  rom_addr, pc, pc_plus4, if_valid, flush, epc_we, epc, irq_ack
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               jr, jr_target, irq, exc,
        output rom_addr, pc, pc_plus4, if_valid, flush, epc_we, epc, irq_ack
    );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC priority mux: exc > jr > jump > branch > irq > stall > pc+4.
// The exc leg and its vector exist only when FETCH_EXC_EN is defined.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  word_t pc,
    input  word_t pc_plus4,
    input  logic  stall,
    input  logic  branch_taken,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    input  logic  jr,
    input  word_t jr_target,
    input  logic  irq_en,
    input  logic  irq,
    input  logic  exc,
    output word_t next_pc,
    output logic  redirect,
    output logic  hold,
    output logic  irq_take,
    output logic  exc_take
);

    word_t jump_pc;
    word_t branch_pc;

    assign jump_pc   = {pc[31], pc_plus4[30:28], jump_target[27:2], 2'b00};
    assign branch_pc = {pc[31], branch_target[30:0]};

    // Bits dropped by the target formats; kept visible so lint sees them consumed.
    logic unused_bits;
    assign unused_bits = &{1'b0, jump_target[31:28], jump_target[1:0],
                           branch_target[31], pc_plus4[31]};

`ifndef FETCH_EXC_EN
    logic unused_exc;
    assign unused_exc = exc;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_pc  = pc_plus4;
        hold     = 1'b0;
        irq_take = 1'b0;
        exc_take = 1'b0;
`ifdef FETCH_EXC_EN
        if (exc) begin
            next_pc  = EXC_VEC;
            exc_take = 1'b1;
        end else
`endif
        if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end else if (irq_en && irq && !stall) begin
            next_pc  = IRQ_VEC;
            irq_take = 1'b1;
        end else if (stall) begin
            next_pc = pc;
            hold    = 1'b1;
        end
        redirect = exc_take | jr | jump | branch_taken | irq_take;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, BOOT/RUN/TRAP FSM and trap entry.
// Define FETCH_EXC_EN to enable the undefined-instruction exception path.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);

    state_t state;
    word_t  pc_q;
    word_t  epc_q;
    logic   if_valid_q;
    logic   epc_we_q;
    logic   irq_ack_q;

    word_t  pc_plus4;
    word_t  next_pc;
    logic   redirect;
    logic   hold;
    logic   irq_take;
    logic   exc_take;
    logic   irq_en;

    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
    // Interrupts only interrupt user-mode code running normally.
    assign irq_en   = (state == RUN) && !pc_q[31];

    fetch_next_pc u_next_pc (
        .pc            (pc_q),
        .pc_plus4      (pc_plus4),
        .stall         (bus.stall),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .jr            (bus.jr),
        .jr_target     (bus.jr_target),
        .irq_en        (irq_en),
        .irq           (bus.irq),
        .exc           (bus.exc),
        .next_pc       (next_pc),
        .redirect      (redirect),
        .hold          (hold),
        .irq_take      (irq_take),
        .exc_take      (exc_take)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            pc_q       <= RESET_VEC;
            if_valid_q <= 1'b0;
            epc_q      <= '0;
            epc_we_q   <= 1'b0;
            irq_ack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            epc_we_q  <= 1'b0;
            irq_ack_q <= 1'b0;
            case (state)
                BOOT: begin
                    pc_q       <= pc_plus4;
                    if_valid_q <= 1'b1;
                    state      <= RUN;
                end
                default: begin
                    pc_q <= next_pc;
                    if (!hold) if_valid_q <= 1'b1;
                    if (exc_take) begin
                        epc_q    <= pc_plus4;
                        epc_we_q <= 1'b1;
                        state    <= TRAP;
                    end else if (irq_take) begin
                        epc_q     <= pc_q;
                        epc_we_q  <= 1'b1;
                        irq_ack_q <= 1'b1;
                        state     <= TRAP;
                    end else if (state == TRAP && bus.jr && !bus.jr_target[31]) begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.rom_addr = pc_q[30:0];
    assign bus.if_valid = if_valid_q;
    assign bus.flush    = (state != BOOT) && redirect;
    assign bus.epc      = epc_q;
    assign bus.epc_we   = epc_we_q;
    assign bus.irq_ack  = irq_ack_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL declare port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL declare port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL declare port stall, input, 1, hold the PC (IF/ID busy, load-use hazard).
REQ-004 SHALL declare ports branch_taken (input, 1) and branch_target (input, 32), a resolved taken branch and its target.
REQ-005 SHALL declare ports jump (input, 1) and jump_target (input, 32), j/jal target with bits [27:0] valid.
REQ-006 SHALL declare ports jr (input, 1) and jr_target (input, 32), the register-indirect target; bit 31 selects supervisor mode.
REQ-007 SHALL declare port irq, input, 1, level timer interrupt request.
REQ-008 SHALL declare port exc, input, 1, undefined-instruction pulse.
REQ-009 SHALL declare port rom_addr, output, 31, instruction ROM address, equal to pc[30:0].
REQ-010 SHALL declare ports pc and pc_plus4, both output, 32, current fetch PC and pc+4 with bit 31 kept.
REQ-011 SHALL declare port if_valid, output, 1, fetched word is valid for IF/ID.
REQ-012 SHALL declare port flush, output, 1, squash the IF/ID instruction.
REQ-013 SHALL declare ports epc_we (output, 1) and epc (output, 32), write of the return address into $k0 ($26).
REQ-014 SHALL declare port irq_ack, output, 1, one-cycle acknowledge to the timer.

Function
REQ-015 SHALL implement the states BOOT, RUN and TRAP.
REQ-016 BOOT SHALL last exactly one cycle after reset deasserts, with if_valid=0 and pc=0x80000000, and then go to RUN.
REQ-017 In RUN and TRAP, next-PC priority SHALL be exc > jr > jump > branch_taken > irq > stall > pc_plus4.
REQ-018 A jump SHALL produce {pc[31], pc_plus4[30:28], jump_target[27:2], 2'b00}.
REQ-019 A branch SHALL load branch_target with bit 31 forced to pc[31].
REQ-020 A jr SHALL load jr_target unchanged.
REQ-021 Any redirect (exc, jr, jump, branch, irq) SHALL assert flush for that cycle and override stall.
REQ-022 An irq SHALL be taken only in RUN, with pc[31]=0, no redirect and no stall in the same cycle; otherwise it stays pending.
REQ-023 Taking an irq SHALL:
- load pc=0x80000004;
- drive epc=pc and epc_we=1;
- pulse irq_ack;
- enter TRAP.
REQ-024 An exc SHALL load pc=0x80000008, drive epc=pc+4 and epc_we=1, and enter TRAP; this applies from RUN or TRAP.
REQ-025 TRAP SHALL return to RUN on a jr whose jr_target[31]=0; irq SHALL be ignored while in TRAP.
REQ-026 Under stall without a redirect, pc, if_valid and the state SHALL hold.
REQ-027 pc_plus4 SHALL wrap bits [30:0] modulo 2^31 and preserve bit 31.
REQ-028 Outputs SHALL be registered except rom_addr, pc_plus4 and flush.

Reset
REQ-029 While reset is high, outputs SHALL be:
- pc=0x80000000, rom_addr=0, pc_plus4=0x80000004;
- if_valid=0, flush=0, epc_we=0, epc=0, irq_ack=0;
- state=BOOT.
REQ-030 A reset asserted mid-operation, including mid-TRAP, SHALL abort immediately to these values with no epc write.

Configuration
REQ-031 When FETCH_EXC_EN is defined, exc SHALL behave as in REQ-024.
REQ-032 When FETCH_EXC_EN is undefined, exc SHALL be ignored, the 0x80000008 vector logic is absent, and the priority starts at jr.

Structure
REQ-033 Package fetch_pkg SHALL hold:
- the vectors RESET_VEC=0x80000000, IRQ_VEC=0x80000004 and EXC_VEC=0x80000008;
- the state encoding;
- the 32-bit width constant.
REQ-034 One combinational sub-module, fetch_next_pc, SHALL hold the REQ-017 priority mux; the FSM and registers stay in fetch_ctrl.

Verification
REQ-035 Reset release with no events -> one cycle if_valid=0 at pc 0x80000000, then pc 0x80000004, 0x80000008, ... with if_valid=1.
REQ-036 Asserting irq in RUN with pc=0x00000040 and no stall -> next pc=0x80000004, epc=0x00000040, epc_we=1, irq_ack=1, flush=1; then jr_target=0x00000040 returns the bench to RUN.
REQ-037 irq and branch_taken (target 0x00000100) in the same cycle -> pc=0x00000100 first, then irq is taken the following cycle.
REQ-038 stall held 3 cycles at pc=0x00000020 -> pc is unchanged, and jump_target=0x000000C0 during the stall gives pc=0x000000C0 with flush=1.
REQ-039 With FETCH_EXC_EN defined, exc at pc=0x00000010 -> pc=0x80000008, epc=0x00000014; with it undefined, pc=0x00000014.
REQ-040 Asserting reset during TRAP at pc=0x80000050 -> pc=0x80000000 immediately, epc_we=0, state BOOT.
